// File: rtl/ble_usb_arb_pkg.sv
// rtl/ble_usb_arb_pkg.sv - shared types and helpers for the BLE-to-USB frame arbiter
package ble_usb_arb_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

  // Bit offset of source k inside the packed per-source data bus.
  function automatic int src_offset(input int k);
    return k * BYTE_W;
  endfunction

endpackage

// File: rtl/ble_usb_frame_arbiter_if.sv
// rtl/ble_usb_frame_arbiter_if.sv - source-side and USB-side signals of the frame arbiter
interface ble_usb_frame_arbiter_if #(
  parameter int NB_SRC = 4
);
  import ble_usb_arb_pkg::*;

  logic [NB_SRC-1:0]          src_valid_i;
  logic [BYTE_W*NB_SRC-1:0]   src_data_i;
  logic [NB_SRC-1:0]          src_last_i;
  logic [NB_SRC-1:0]          src_ready_o;
  logic [BYTE_W-1:0]          data_o;
  logic                       valid_o;
  logic                       frame_o;
  logic [$clog2(NB_SRC)-1:0]  grant_o;
  logic                       abort_o;

  modport slave (
    input  src_valid_i, src_data_i, src_last_i,
    output src_ready_o, data_o, valid_o, frame_o, grant_o, abort_o
  );

  modport master (
    output src_valid_i, src_data_i, src_last_i,
    input  src_ready_o, data_o, valid_o, frame_o, grant_o, abort_o
  );

endinterface

// File: rtl/ble_rr_picker.sv
// rtl/ble_rr_picker.sv - first requester at or after the pointer, wrapping modulo NB_SRC
module ble_rr_picker #(
  parameter int NB_SRC = 4
) (
  input  logic [NB_SRC-1:0]         req_i,
  input  logic [$clog2(NB_SRC)-1:0] ptr_i,
  output logic                      found_o,
  output logic [$clog2(NB_SRC)-1:0] idx_o
);
  localparam int IW = $clog2(NB_SRC);

  int k;

  // Walk from the farthest offset down so the nearest requester wins last.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    k       = 0;
    for (int i = NB_SRC - 1; i >= 0; i--) begin
      k = (int'(ptr_i) + i) % NB_SRC;
      if (req_i[k]) begin
        found_o = 1'b1;
        idx_o   = IW'(k);
      end
    end
  end

endmodule

// File: rtl/ble_usb_frame_arbiter.sv
// rtl/ble_usb_frame_arbiter.sv - round-robin frame arbiter sharing one USB byte stream between BLE sources
module ble_usb_frame_arbiter
  import ble_usb_arb_pkg::*;
#(
  parameter int NB_SRC     = 4,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  ble_usb_frame_arbiter_if.slave bus
);
  localparam int IW = $clog2(NB_SRC);
  localparam int SW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [SW-1:0] STALL_LAST = SW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);
  localparam logic [IW-1:0] IDX_MAX    = IW'(NB_SRC - 1);

  arb_state_e        state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     grant_q, grant_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              frame_q, frame_d;
  logic              abort_q, abort_d;
  logic [SW-1:0]     stall_q, stall_d;
  logic [GW-1:0]     gap_q, gap_d;

  logic [NB_SRC-1:0] ready;
  logic              accept;
  logic [BYTE_W-1:0] cur_byte;
  logic              cur_last;
  logic [IW-1:0]     next_ptr;
  logic              pick_found;
  logic [IW-1:0]     pick_idx;

  ble_rr_picker #(
    .NB_SRC (NB_SRC)
  ) u_picker (
    .req_i   (bus.src_valid_i),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    frame_d  = frame_q;
    abort_d  = 1'b0;
    stall_d  = stall_q;
    gap_d    = gap_q;
    ready    = '0;
    accept   = 1'b0;
    cur_byte = bus.src_data_i[src_offset(int'(grant_q)) +: BYTE_W];
    cur_last = bus.src_last_i[grant_q];
    next_ptr = (grant_q == IDX_MAX) ? '0 : grant_q + 1'b1;

    case (state_q)
      IDLE: begin
        frame_d = 1'b0;
        if (pick_found) begin
          grant_d = pick_idx;
          stall_d = '0;
          state_d = XFER;
        end
      end

      XFER: begin
        ready[grant_q] = 1'b1;
        accept         = bus.src_valid_i[grant_q];
        if (accept) begin
          data_d  = cur_byte;
          valid_d = 1'b1;
          frame_d = 1'b1;
          stall_d = '0;
          if (cur_last) begin
            state_d = GAP;
            gap_d   = '0;
            ptr_d   = next_ptr;
          end
        end else if (stall_q == STALL_LAST) begin
          // This idle cycle is the TIMEOUT-th in a row: drop the frame.
          frame_d = 1'b0;
          abort_d = 1'b1;
          stall_d = '0;
          state_d = GAP;
          gap_d   = '0;
          ptr_d   = next_ptr;
        end else begin
          stall_d = stall_q + 1'b1;
        end
      end

      GAP: begin
        frame_d = 1'b0;
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end

      default: begin
        frame_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      frame_q <= 1'b0;
      abort_q <= 1'b0;
      stall_q <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      frame_q <= frame_d;
      abort_q <= abort_d;
      stall_q <= stall_d;
      gap_q   <= gap_d;
    end
  end

  // Ready is decoded from registered state only, so it also drops with reset.
  assign bus.src_ready_o = ready;
  assign bus.data_o      = data_q;
  assign bus.valid_o     = valid_q;
  assign bus.frame_o     = frame_q;
  assign bus.grant_o     = grant_q;
  assign bus.abort_o     = abort_q;

endmodule

// File: tb/tb_ble_usb_frame_arbiter.sv
// tb/tb_ble_usb_frame_arbiter.sv - directed scoreboard bench for ble_usb_frame_arbiter
module tb_ble_usb_frame_arbiter;

  localparam int NB     = 4;
  localparam int GAP    = 2;
  localparam int TMO    = 64;
  localparam int BUDGET = 300;

  typedef struct {
    logic [7:0] data;
    logic       last;
    int         pre;
  } feed_t;

  typedef struct {
    int         src;
    logic [7:0] data;
  } exp_t;

  logic clk;
  logic rst;

  ble_usb_frame_arbiter_if #(.NB_SRC(NB)) bus ();

  ble_usb_frame_arbiter #(
    .NB_SRC     (NB),
    .GAP_CYCLES (GAP),
    .TIMEOUT    (TMO)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  feed_t feed_q[NB][$];
  exp_t  sb_q[$];
  int    dly[NB];
  bit    loaded[NB];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    n_abort  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic push(input int k, input logic [7:0] d, input logic l, input int pre);
    feed_t f;
    exp_t  e;
    f.data = d;
    f.last = l;
    f.pre  = pre;
    feed_q[k].push_back(f);
    e.src  = k;
    e.data = d;
    sb_q.push_back(e);
  endtask

  task automatic wait_start(input string tag);
    logic prev;
    int   n;
    prev = bus.frame_o;
    n    = 0;
    while (n < BUDGET) begin
      tick();
      n++;
      if (bus.frame_o && !prev) break;
      prev = bus.frame_o;
    end
    chk({tag, "_start_in_time"}, n < BUDGET, 1);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || bus.frame_o) && n < BUDGET) begin
      tick();
      n++;
    end
    chk({tag, "_drain_in_time"}, n < BUDGET, 1);
  endtask

  // Source models: present the queue head, pop it once the arbiter accepted it.
  initial begin : feeder
    logic [NB-1:0] acc;
    forever begin
      @(negedge clk);
      acc = bus.src_valid_i & bus.src_ready_o;
      @(posedge clk);
      #1;
      for (int k = 0; k < NB; k++) begin
        if (acc[k] && feed_q[k].size() > 0) begin
          void'(feed_q[k].pop_front());
          loaded[k] = 1'b0;
        end
        if (feed_q[k].size() == 0) begin
          loaded[k]            = 1'b0;
          bus.src_valid_i[k]   = 1'b0;
        end else begin
          if (!loaded[k]) begin
            dly[k]    = feed_q[k][0].pre;
            loaded[k] = 1'b1;
          end
          if (dly[k] > 0) begin
            bus.src_valid_i[k] = 1'b0;
            dly[k]--;
          end else begin
            bus.src_valid_i[k]       = 1'b1;
            bus.src_data_i[8*k +: 8] = feed_q[k][0].data;
            bus.src_last_i[k]        = feed_q[k][0].last;
          end
        end
      end
    end
  end

  initial begin : monitor
    int   zero_run;
    bit   seen_frame;
    bit   frame_prev;
    exp_t e;
    zero_run   = 0;
    seen_frame = 1'b0;
    frame_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        zero_run   = 0;
        seen_frame = 1'b0;
        frame_prev = 1'b0;
      end else begin
        if (bus.valid_o) begin
          chk("valid_implies_frame", bus.frame_o, 1);
          chk("sb_byte_expected", sb_q.size() != 0, 1);
          if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("sb_data", bus.data_o, e.data);
            chk("sb_grant", bus.grant_o, e.src);
          end
        end
        if (bus.frame_o && !frame_prev) begin
          if (seen_frame) chk("inter_frame_gap", zero_run >= GAP + 1, 1);
          seen_frame = 1'b1;
        end
        zero_run   = bus.frame_o ? 0 : zero_run + 1;
        frame_prev = bus.frame_o;
        if (bus.abort_o) n_abort++;
      end
    end
  end

  initial begin : stimulus
    logic [7:0] ev;
    bit         bad;
    rst             = 1'b1;
    bus.src_valid_i = '0;
    bus.src_data_i  = '0;
    bus.src_last_i  = '0;
    for (int k = 0; k < NB; k++) begin
      dly[k]    = 0;
      loaded[k] = 1'b0;
    end
    repeat (3) tick();
    chk("rst_data", bus.data_o, 0);
    chk("rst_valid", bus.valid_o, 0);
    chk("rst_frame", bus.frame_o, 0);
    chk("rst_grant", bus.grant_o, 0);
    chk("rst_abort", bus.abort_o, 0);
    chk("rst_ready", bus.src_ready_o, 0);
    rst = 1'b0;
    tick();

    // All four sources request two-byte frames together.
    for (int k = 0; k < NB; k++) begin
      push(k, 8'(16 * (k + 1)), 1'b0, 0);
      push(k, 8'(16 * (k + 1) + 1), 1'b1, 0);
    end
    wait_drain("rr4");
    repeat (4) tick();

    // Source 0 alone, exact cycle timing of a three-byte frame.
    push(0, 8'hA1, 1'b0, 0);
    push(0, 8'hA2, 1'b0, 0);
    push(0, 8'hA3, 1'b1, 0);
    for (int i = 1; i <= 7; i++) begin
      tick();
      ev = (i >= 3 && i <= 5) ? 8'(8'hA0 + i - 2) : 8'h00;
      chk($sformatf("t1_valid_c%0d", i), bus.valid_o, (ev != 0));
      chk($sformatf("t1_frame_c%0d", i), bus.frame_o, (ev != 0));
      if (ev != 0) chk($sformatf("t1_data_c%0d", i), bus.data_o, ev);
    end
    chk("t1_grant", bus.grant_o, 0);
    repeat (4) tick();

    // Source 2 with a five-cycle bubble inside the frame.
    push(2, 8'h50, 1'b0, 0);
    push(2, 8'h51, 1'b1, 5);
    wait_start("bubble");
    chk("bubble_first", bus.data_o, 8'h50);
    for (int j = 1; j <= 5; j++) begin
      tick();
      chk($sformatf("bubble_valid_%0d", j), bus.valid_o, 0);
      chk($sformatf("bubble_frame_%0d", j), bus.frame_o, 1);
    end
    tick();
    chk("bubble_last_valid", bus.valid_o, 1);
    chk("bubble_last_data", bus.data_o, 8'h51);
    wait_drain("bubble");
    chk("bubble_no_abort", n_abort, 0);
    repeat (4) tick();

    // Source 1 stalls forever after one byte; source 3 waits behind it.
    push(1, 8'h55, 1'b0, 0);
    wait_start("tmo");
    chk("tmo_grant", bus.grant_o, 1);
    push(3, 8'h77, 1'b1, 0);
    bad = 1'b0;
    for (int i = 1; i < 64; i++) begin
      tick();
      if (!bus.frame_o || bus.abort_o) bad = 1'b1;
    end
    chk("tmo_frame_held", bad, 0);
    tick();
    chk("tmo_abort", bus.abort_o, 1);
    chk("tmo_frame_fall", bus.frame_o, 0);
    chk("tmo_valid", bus.valid_o, 0);
    tick();
    chk("tmo_abort_pulse", bus.abort_o, 0);
    wait_start("tmo_next");
    chk("tmo_next_grant", bus.grant_o, 3);
    wait_drain("tmo");
    chk("tmo_abort_count", n_abort, 1);
    repeat (4) tick();

    // Source 3 finishes while 0 and 3 both keep requesting.
    push(3, 8'h90, 1'b0, 0);
    push(3, 8'h91, 1'b1, 0);
    wait_start("wrap");
    chk("wrap_first", bus.grant_o, 3);
    push(0, 8'hB0, 1'b1, 0);
    push(3, 8'h92, 1'b1, 0);
    wait_start("wrap_next");
    chk("wrap_grant", bus.grant_o, 0);
    wait_drain("wrap");
    repeat (4) tick();

    // Single-byte frame moves the pointer to 2 before the reset test.
    push(1, 8'h33, 1'b1, 0);
    wait_drain("single");
    repeat (4) tick();

    // Reset in the middle of a four-byte frame from source 2.
    push(2, 8'h60, 1'b0, 0);
    push(2, 8'h61, 1'b0, 0);
    push(2, 8'h62, 1'b0, 0);
    push(2, 8'h63, 1'b1, 0);
    wait_start("mid");
    chk("mid_byte1", bus.data_o, 8'h60);
    tick();
    chk("mid_byte2", bus.data_o, 8'h61);
    chk("mid_grant", bus.grant_o, 2);
    rst = 1'b1;
    #1;
    chk("mid_rst_data", bus.data_o, 0);
    chk("mid_rst_valid", bus.valid_o, 0);
    chk("mid_rst_frame", bus.frame_o, 0);
    chk("mid_rst_grant", bus.grant_o, 0);
    chk("mid_rst_ready", bus.src_ready_o, 0);
    for (int k = 0; k < NB; k++) feed_q[k].delete();
    sb_q.delete();
    repeat (2) tick();
    rst = 1'b0;
    tick();
    push(0, 8'hC0, 1'b1, 0);
    push(3, 8'hC3, 1'b1, 0);
    wait_start("post_rst");
    chk("post_rst_grant", bus.grant_o, 0);
    chk("post_rst_data", bus.data_o, 8'hC0);
    wait_drain("post_rst");
    repeat (4) tick();

    chk("final_abort_count", n_abort, 1);
    chk("final_sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
